// File: rtl/rv_pkg.sv
// Shared RV pipeline types: ALU select encodings and the ID/EX register payload.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RLEN = 5;
  localparam int unsigned SELW = 4;

  typedef enum logic [SELW-1:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_LUI   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_AUIPC = 4'b1001
  } alu_sel_t;

  // All-zero value is the bubble: no control, rd=x0, select ADD, zero data.
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [RLEN-1:0] rd;
    logic [RLEN-1:0] rs1;
    logic [RLEN-1:0] rs2;
    alu_sel_t        alu_sel;
    logic            src_a;
    logic            src_b;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB beats register-file data; x0 never forwards.
module fwd_mux #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RLEN = 5
) (
  input  logic [RLEN-1:0] i_rs,
  input  logic [XLEN-1:0] i_reg_data,
  input  logic            i_exmem_reg_write,
  input  logic [RLEN-1:0] i_exmem_rd,
  input  logic [XLEN-1:0] i_exmem_result,
  input  logic            i_memwb_reg_write,
  input  logic [RLEN-1:0] i_memwb_rd,
  input  logic [XLEN-1:0] i_memwb_result,
  output logic [XLEN-1:0] o_fwd_data
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_rs);
  assign w_memwb_hit = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_rs);

  always_comb begin
    o_fwd_data = i_reg_data;
    if (w_exmem_hit) begin
      o_fwd_data = i_exmem_result;
    end else if (w_memwb_hit) begin
      o_fwd_data = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Build option: ID_EX_FORWARD_EN enables the forward muxes; otherwise every RAW is flagged as a hazard.
module id_ex_stage #(
  parameter int unsigned XLEN = rv_pkg::XLEN,
  parameter int unsigned RLEN = rv_pkg::RLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RLEN-1:0] id_rs1,
  input  logic [RLEN-1:0] id_rs2,
  input  logic [RLEN-1:0] id_rd,
  input  logic [3:0]      id_alu_sel,
  input  logic            id_src_a,
  input  logic            id_src_b,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RLEN-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RLEN-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [RLEN-1:0] ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_hazard
);

  import rv_pkg::id_ex_t;
  import rv_pkg::alu_sel_t;

  id_ex_t          r_ex;
  id_ex_t          w_ex_nxt;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  logic            w_ex_producer;
  logic            w_rs_match;

  // Priority below reset: flush > stall > load.
  always_comb begin
    w_ex_nxt = r_ex;
    if (flush) begin
      w_ex_nxt = '0;
    end else if (!stall) begin
      w_ex_nxt.valid     = id_valid;
      w_ex_nxt.reg_write = id_valid & id_reg_write;
      w_ex_nxt.mem_read  = id_valid & id_mem_read;
      w_ex_nxt.mem_write = id_valid & id_mem_write;
      w_ex_nxt.rd        = id_rd;
      w_ex_nxt.rs1       = id_rs1;
      w_ex_nxt.rs2       = id_rs2;
      w_ex_nxt.alu_sel   = alu_sel_t'(id_alu_sel);
      w_ex_nxt.src_a     = id_src_a;
      w_ex_nxt.src_b     = id_src_b;
      w_ex_nxt.pc        = id_pc;
      w_ex_nxt.rs1_data  = id_rs1_data;
      w_ex_nxt.rs2_data  = id_rs2_data;
      w_ex_nxt.imm       = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_ex_nxt;
    end
  end

`ifdef ID_EX_FORWARD_EN
  fwd_mux #(.XLEN(XLEN), .RLEN(RLEN)) u_fwd_rs1 (
    .i_rs              (r_ex.rs1),
    .i_reg_data        (r_ex.rs1_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_fwd_data        (w_rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RLEN(RLEN)) u_fwd_rs2 (
    .i_rs              (r_ex.rs2),
    .i_reg_data        (r_ex.rs2_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_fwd_data        (w_rs2_fwd)
  );

  // Only a load's value arrives too late to forward.
  assign w_ex_producer = r_ex.mem_read;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, r_ex.rs1, r_ex.rs2};

  assign w_rs1_fwd     = r_ex.rs1_data;
  assign w_rs2_fwd     = r_ex.rs2_data;
  // Without forwarding any in-flight register write is a hazard.
  assign w_ex_producer = r_ex.mem_read | r_ex.reg_write;
`endif

  assign w_rs_match      = (r_ex.rd == id_rs1) || (r_ex.rd == id_rs2);
  assign load_use_hazard = r_ex.valid & w_ex_producer & (r_ex.rd != '0) & id_valid & w_rs_match;

  assign alu_a         = r_ex.src_a ? r_ex.pc  : w_rs1_fwd;
  assign alu_b         = r_ex.src_b ? r_ex.imm : w_rs2_fwd;
  assign ex_store_data = w_rs2_fwd;
  assign alu_sel       = 4'(r_ex.alu_sel);
  assign ex_valid      = r_ex.valid;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_rd         = r_ex.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow the ID_EX_FORWARD_EN build setting.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_sel;
  logic        id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_sel;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [4:0]  ex_rd;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_sel(id_alu_sel),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  rd;
    logic [31:0] st;
    logic        luh;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=0x%08h expected=0x%08h", n, f, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        cmp(n, "alu_a", alu_a, e.a);
        cmp(n, "alu_b", alu_b, e.b);
        cmp(n, "alu_sel", 32'(alu_sel), 32'(e.sel));
        cmp(n, "ex_valid", 32'(ex_valid), 32'(e.v));
        cmp(n, "ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        cmp(n, "ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        cmp(n, "ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
        cmp(n, "ex_rd", 32'(ex_rd), 32'(e.rd));
        cmp(n, "ex_store_data", ex_store_data, e.st);
        cmp(n, "load_use_hazard", 32'(load_use_hazard), 32'(e.luh));
      end
    end
  end

  task automatic expect_out(input string n, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] sel, input logic v, input logic rw, input logic mr,
                            input logic mw, input logic [4:0] rd, input logic [31:0] st,
                            input logic luh);
    exp_t e;
    e = '{a: a, b: b, sel: sel, v: v, rw: rw, mr: mr, mw: mw, rd: rd, st: st, luh: luh};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic expect_bubble(input string n);
    expect_out(n, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                          input logic [31:0] r2d, input logic [31:0] imm, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic [3:0] sel,
                          input logic sa, input logic sb, input logic rw, input logic mr,
                          input logic mw);
    id_valid = v; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_sel = sel;
    id_src_a = sa; id_src_b = sb; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = erw; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mrw; memwb_rd = mrd; memwb_result = mres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 32'h100, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd9, 4'h1,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    drive_id(1'b1, 32'h40, 32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 5'd3, 4'h0,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_bubble("reset");

    step();
    drive_id(1'b1, 32'h80, 32'h55, 32'h66, 32'h10, 5'd3, 5'd0, 5'd5, 4'h3,
             1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("plain_load", 32'd5, 32'd7, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'd9, !FWD);

    step();
    drive_id(1'b1, 32'hC0, 32'h99, 32'h44, 32'h0, 5'd0, 5'd0, 5'd0, 4'h4,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    expect_out("fwd_exmem", FWD ? 32'hAA : 32'h55, 32'h66, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0,
               5'd5, 32'h66, 1'b0);

    step();
    exmem_reg_write = 1'b0;
    expect_out("fwd_memwb", FWD ? 32'hBB : 32'h55, 32'h66, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0,
               5'd5, 32'h66, 1'b0);

    step();
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b0, 5'd3, 32'hBB);
    expect_out("fwd_x0", 32'h55, 32'h66, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h66, 1'b0);

    step();
    stall = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_out("fwd_none", 32'h55, 32'h66, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h66, 1'b0);

    step();
    drive_id(1'b1, 32'h200, 32'h1000, 32'h2000, 32'hFFFF_FFFF, 5'd6, 5'd7, 5'd8, 4'h1,
             1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    expect_out("rs_zero", 32'h99, 32'h44, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h44, 1'b0);

    step();
    drive_id(1'b1, 32'h300, 32'hAB, 32'hCD, 32'h5, 5'd8, 5'd1, 5'd2, 4'h8,
             1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    stall = 1'b1;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
    expect_out("sub_load", 32'h200, 32'hFFFF_FFFF, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,
               FWD ? 32'h1234 : 32'h2000, !FWD);

    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) flush = 1'b1;
      expect_out("stall_hold", 32'h200, 32'hFFFF_FFFF, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,
                 FWD ? 32'h1234 : 32'h2000, !FWD);
    end

    step();
    flush = 1'b0; stall = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_bubble("flush_stall");

    step();
    drive_id(1'b1, 32'h400, 32'd1, 32'd2, 32'd3, 5'd5, 5'd2, 5'd6, 4'h2,
             1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    expect_out("load_use", 32'hAB, 32'h5, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'hCD, 1'b1);

    step();
    id_valid = 1'b0;
    rst = 1'b1;
    expect_out("load_use_idle", 32'hAB, 32'h5, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'hCD, 1'b0);

    step();
    rst = 1'b0; stall = 1'b0;
    expect_bubble("rst_in_stall");

    step();
    set_fwd(1'b1, 5'd2, 32'hEE, 1'b1, 5'd5, 32'hDD);
    expect_out("invalid_load", FWD ? 32'hDD : 32'd1, FWD ? 32'hEE : 32'd2, 4'h2,
               1'b0, 1'b0, 1'b0, 1'b0, 5'd6, FWD ? 32'hEE : 32'd2, 1'b0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
